// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 bus control strobes between host (master) and LCD responder (slave).
// Carries E, RS and RW. The 8-bit data bus stays a plain inout port on the responder
// so its tristate is resolved at the module boundary.
interface lcd_hd44780_responder_if;
  logic LCD_E;   // enable strobe, access completes on falling edge
  logic LCD_RS;  // 0 = instruction/status, 1 = data
  logic LCD_RW;  // 0 = write, 1 = read

  modport master (output LCD_E, LCD_RS, LCD_RW);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780 character-LCD responder: decodes host accesses on synchronized E falling edge,
// holds 80-byte DDRAM, 64-byte CGRAM, address counter and busy flag, serves status/data reads.
// Ports: clk/reset_n, lcd (E/RS/RW), LCD_data (tristate), scan_addr/scan_data (1-cycle DDRAM
// scan), busy, ac, disp_ctrl, func_n, cmd_dropped (pulse when an access is ignored due to BF).
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  lcd_hd44780_responder_if.slave      lcd,
  inout  wire  [7:0]                  LCD_data,
  input  logic [6:0]                  scan_addr,
  output logic [7:0]                  scan_data,
  output logic                        busy,
  output logic [6:0]                  ac,
  output logic [2:0]                  disp_ctrl,
  output logic                        func_n,
  output logic                        cmd_dropped
);

  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);

  typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;

  fill_state_t   state, state_nx;
  logic [6:0]    fill_idx;
  logic [CW-1:0] busy_cnt;
  logic [10:0]   sync1, sync2;
  logic          e_prev;
  logic          id, cg_mode, reload;
  logic [7:0]    rd_latch;
  logic [7:0]    ddram [0:79];
  logic [7:0]    cgram [0:63];

  // DDRAM index: in 2-line mode the second line 0x40-0x67 packs onto 40-79;
  // anything outside the legal map folds modulo 80.
  function automatic logic [6:0] dd_index(input logic [6:0] a, input logic two_line);
    if (two_line && a >= 7'h40 && a <= 7'h67) return a - 7'd24;
    else if (a >= 7'd80)                       return a - 7'd80;
    else                                       return a;
  endfunction

  // Address counter step; out-of-range values land back on the legal map.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                         input logic two_line, input logic cg);
    if (cg) return up ? {1'b0, a[5:0] + 6'd1} : {1'b0, a[5:0] - 6'd1};
    if (two_line) begin
      if (up) begin
        if (a < 7'h27)      return a + 7'd1;
        else if (a < 7'h40) return 7'h40;
        else if (a < 7'h67) return a + 7'd1;
        else                return 7'h00;
      end else begin
        if (a == 7'h00)      return 7'h67;
        else if (a <= 7'h27) return a - 7'd1;
        else if (a <= 7'h40) return 7'h27;
        else if (a <= 7'h67) return a - 7'd1;
        else                 return 7'h67;
      end
    end
    if (up) return (a < 7'h4F) ? a + 7'd1 : 7'h00;
    if (a == 7'h00)      return 7'h4F;
    else if (a <= 7'h4F) return a - 7'd1;
    else                 return 7'h4F;
  endfunction

  // RS/RW/data come from the same stage as E so they describe the same access.
  logic       s_e, s_rs, s_rw;
  logic [7:0] s_dat;
  assign {s_e, s_rs, s_rw, s_dat} = sync2;

  logic access, status_rd, honoured, instr_wr, data_wr, data_rd, clear_evt;
  assign access    = e_prev & ~s_e;
  assign status_rd = access & ~s_rs & s_rw;
  assign honoured  = access & ~status_rd & ~busy;
  assign instr_wr  = honoured & ~s_rs & ~s_rw;
  assign data_wr   = honoured &  s_rs & ~s_rw;
  assign data_rd   = honoured &  s_rs &  s_rw;
  assign clear_evt = instr_wr & (s_dat == 8'h01);

  assign busy = (state == ST_FILL) || (busy_cnt != '0);

  // Bus is driven combinationally from the raw strobes so the host sees data while E is high.
  assign LCD_data = (lcd.LCD_E && lcd.LCD_RW) ? (lcd.LCD_RS ? rd_latch : {busy, ac}) : 8'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      e_prev <= 1'b0;
    end else begin
      sync1  <= {lcd.LCD_E, lcd.LCD_RS, lcd.LCD_RW, LCD_data};
      sync2  <= sync1;
      e_prev <= s_e;
    end
  end

  // Fill engine: writes 0x20 to one DDRAM byte per cycle after reset and after clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FILL;
      fill_idx <= 7'd0;
    end else begin
      state    <= state_nx;
      fill_idx <= (state == ST_FILL && state_nx == ST_FILL) ? fill_idx + 7'd1 : 7'd0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FILL: if (fill_idx == 7'd79) state_nx = ST_IDLE;
      ST_IDLE: if (clear_evt)         state_nx = ST_FILL;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_FILL) ddram[fill_idx] <= 8'h20;
    else if (data_wr) begin
      if (cg_mode) cgram[ac[5:0]] <= s_dat;
      else         ddram[dd_index(ac, func_n)] <= s_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt    <= '0;
      ac          <= 7'd0;
      id          <= 1'b1;
      disp_ctrl   <= 3'b000;
      func_n      <= 1'b0;
      cg_mode     <= 1'b0;
      rd_latch    <= 8'h00;
      reload      <= 1'b0;
      cmd_dropped <= 1'b0;
      scan_data   <= 8'h00;
    end else begin
      cmd_dropped <= access & ~status_rd & busy;
      reload      <= 1'b0;
      scan_data   <= ddram[dd_index(scan_addr, func_n)];
      if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
      if (instr_wr) begin
        if (s_dat != 8'h00) busy_cnt <= BUSY_LD;
        casez (s_dat)
          8'b1???????: begin ac <= s_dat[6:0]; cg_mode <= 1'b0; reload <= 1'b1; end
          8'b01??????: begin ac <= {1'b0, s_dat[5:0]}; cg_mode <= 1'b1; reload <= 1'b1; end
          8'b001?????: func_n <= s_dat[3];
          8'b0001????: if (!s_dat[3]) ac <= ac_step(ac, s_dat[2], func_n, cg_mode);
          8'b00001???: disp_ctrl <= s_dat[2:0];
          8'b000001??: id <= s_dat[1];
          8'b0000001?: begin ac <= 7'd0; cg_mode <= 1'b0; busy_cnt <= CLEAR_LD; end
          8'b00000001: begin ac <= 7'd0; id <= 1'b1; cg_mode <= 1'b0; busy_cnt <= CLEAR_LD; end
          default: ;
        endcase
      end
      if (data_wr || data_rd) begin
        ac       <= ac_step(ac, id, func_n, cg_mode);
        busy_cnt <= BUSY_LD;
        reload   <= 1'b1;
      end
      // One cycle after the access, AC and RAM already hold their new values.
      if (reload) rd_latch <= cg_mode ? cgram[ac[5:0]] : ddram[dd_index(ac, func_n)];
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
module tb_lcd_hd44780_responder;
  localparam int BUSY  = 60;
  localparam int CLEAR = 150;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lcd_hd44780_responder_if lcd();
  wire  [7:0] LCD_data;
  logic       drv_en = 1'b0;
  logic [7:0] drv_dat = 8'h00;
  logic [6:0] scan_addr = 7'd0;
  logic [7:0] scan_data;
  logic       busy, func_n, cmd_dropped;
  logic [6:0] ac;
  logic [2:0] disp_ctrl;

  assign LCD_data = drv_en ? drv_dat : 8'bz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup pu (LCD_data[gi]);
  end

  lcd_hd44780_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .clk(clk), .reset_n(reset_n), .lcd(lcd), .LCD_data(LCD_data),
    .scan_addr(scan_addr), .scan_data(scan_data), .busy(busy), .ac(ac),
    .disp_ctrl(disp_ctrl), .func_n(func_n), .cmd_dropped(cmd_dropped)
  );

  int nvec = 0;
  int nbad = 0;
  int drop_cnt = 0;
  int run = 0;
  int last_run = 0;

  always @(negedge clk) begin
    if (cmd_dropped) drop_cnt++;
    if (busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    lcd.LCD_RS = rs; lcd.LCD_RW = rw; drv_en = !rw; drv_dat = d;
    @(negedge clk);
    lcd.LCD_E = 1'b1;
    repeat (3) @(negedge clk);
    q = LCD_data;
    lcd.LCD_E = 1'b0;
    repeat (4) @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic wait_ready();
    logic [7:0] q;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      xfer(1'b0, 1'b1, 8'h00, q);
      done = !q[7];
    end
    if (!done) begin
      nvec++; nbad++;
      $display("FAIL wait_ready: BF still 1 after 100 polls, expected 0");
    end
  endtask

  task automatic scan_check(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    scan_addr = a;
    repeat (2) @(negedge clk);
    check($sformatf("scan[0x%0h]", a), scan_data, exp);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " busy"}, busy, 1);
    check({tag, " ac"}, ac, 0);
    check({tag, " disp_ctrl"}, disp_ctrl, 0);
    check({tag, " func_n"}, func_n, 0);
    check({tag, " scan_data"}, scan_data, 0);
    check({tag, " cmd_dropped"}, cmd_dropped, 0);
  endtask

  // Behavioural panel model: the address map is a list of 80 legal addresses.
  logic [7:0] m_dd [80];
  logic [7:0] m_cg [64];
  bit         m_cg_known [64];
  int         m_ac;
  bit         m_id, m_n, m_cg_mode, m_latch_known;
  logic [7:0] m_latch;

  function automatic int legal_addr(input int pos, input bit n);
    return (n && pos >= 40) ? pos + 24 : pos;
  endfunction

  function automatic int pos_of(input int a, input bit n);
    for (int p = 0; p < 80; p++) if (legal_addr(p, n) == a) return p;
    return a % 80;
  endfunction

  function automatic int m_step(input bit up);
    if (m_cg_mode) return (m_ac + (up ? 1 : 63)) % 64;
    return legal_addr((pos_of(m_ac, m_n) + (up ? 1 : 79)) % 80, m_n);
  endfunction

  task automatic m_reload();
    if (m_cg_mode) begin
      m_latch = m_cg[m_ac]; m_latch_known = m_cg_known[m_ac];
    end else begin
      m_latch = m_dd[pos_of(m_ac, m_n)]; m_latch_known = 1;
    end
  endtask

  task automatic rand_op();
    logic [7:0] q, d;
    int r, a;
    bit b0, b1;
    r = $urandom_range(0, 99);
    d = 8'($urandom);
    b0 = 1'($urandom); b1 = 1'($urandom);
    wait_ready();
    if (r < 30) begin
      xfer(1'b1, 1'b0, d, q);
      if (m_cg_mode) begin m_cg[m_ac] = d; m_cg_known[m_ac] = 1; end
      else m_dd[pos_of(m_ac, m_n)] = d;
      m_ac = m_step(m_id); m_reload();
    end else if (r < 45) begin
      xfer(1'b1, 1'b1, 8'h00, q);
      if (m_latch_known) check("rand data read", q, m_latch);
      m_ac = m_step(m_id); m_reload();
    end else if (r < 60) begin
      a = legal_addr($urandom_range(0, 79), m_n);
      xfer(1'b0, 1'b0, 8'h80 | 8'(a), q);
      m_ac = a; m_cg_mode = 0; m_reload();
    end else if (r < 68) begin
      a = $urandom_range(0, 63);
      xfer(1'b0, 1'b0, 8'h40 | 8'(a), q);
      m_ac = a; m_cg_mode = 1; m_reload();
    end else if (r < 76) begin
      xfer(1'b0, 1'b0, {5'b00001, b1, b0}, q);
      m_id = b1;
    end else if (r < 86) begin
      xfer(1'b0, 1'b0, {4'b0001, b1, b0, 2'b00}, q);
      if (!b1) m_ac = m_step(b0);
    end else if (r < 88) begin
      xfer(1'b0, 1'b0, 8'h01, q);
      for (int p = 0; p < 80; p++) m_dd[p] = 8'h20;
      m_ac = 0; m_id = 1; m_cg_mode = 0;
    end else begin
      xfer(1'b0, 1'b1, 8'h00, q);
      check("rand status", q, m_ac);
    end
  endtask

  task automatic rand_phase(input bit n);
    logic [7:0] q;
    wait_ready(); xfer(1'b0, 1'b0, 8'h01, q);
    wait_ready(); xfer(1'b0, 1'b0, n ? 8'h38 : 8'h30, q);
    wait_ready(); xfer(1'b0, 1'b0, 8'h80, q);
    for (int p = 0; p < 80; p++) m_dd[p] = 8'h20;
    m_ac = 0; m_id = 1; m_cg_mode = 0; m_n = n; m_latch = 8'h20; m_latch_known = 1;
    for (int k = 0; k < 120; k++) rand_op();
    wait_ready();
    for (int p = 0; p < 80; p++) scan_check(7'(legal_addr(p, n)), m_dd[p]);
  endtask

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic rw, input logic [7:0] dat,
                              input logic [7:0] exp);
    vec_t v;
    v.rs = rs; v.rw = rw; v.dat = dat; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t tbl [35];
    logic [7:0] q;
    int d0;

    tbl[0]  = mk(0, 1, 8'h00, 8'h00);  // status after fill
    tbl[1]  = mk(0, 0, 8'h38, 8'h00);  // 2-line
    tbl[2]  = mk(0, 0, 8'h06, 8'h00);
    tbl[3]  = mk(0, 0, 8'h0C, 8'h00);
    tbl[4]  = mk(0, 0, 8'h80, 8'h00);
    tbl[5]  = mk(1, 0, 8'h41, 8'h00);
    tbl[6]  = mk(1, 0, 8'h42, 8'h00);
    tbl[7]  = mk(0, 1, 8'h00, 8'h02);
    tbl[8]  = mk(0, 0, 8'h80, 8'h00);
    tbl[9]  = mk(1, 1, 8'h00, 8'h41);
    tbl[10] = mk(1, 1, 8'h00, 8'h42);
    tbl[11] = mk(0, 1, 8'h00, 8'h02);
    tbl[12] = mk(0, 0, 8'hA7, 8'h00);  // AC = 0x27
    tbl[13] = mk(1, 0, 8'h5A, 8'h00);
    tbl[14] = mk(1, 0, 8'h5A, 8'h00);
    tbl[15] = mk(0, 1, 8'h00, 8'h41);
    tbl[16] = mk(0, 0, 8'h04, 8'h00);  // decrement
    tbl[17] = mk(0, 0, 8'hC0, 8'h00);
    tbl[18] = mk(1, 1, 8'h00, 8'h5A);
    tbl[19] = mk(0, 1, 8'h00, 8'h27);  // 0x40 - 1
    tbl[20] = mk(0, 0, 8'h10, 8'h00);  // cursor left
    tbl[21] = mk(0, 1, 8'h00, 8'h26);
    tbl[22] = mk(0, 0, 8'h06, 8'h00);
    tbl[23] = mk(0, 0, 8'h14, 8'h00);  // cursor right
    tbl[24] = mk(0, 0, 8'h14, 8'h00);
    tbl[25] = mk(0, 1, 8'h00, 8'h40);  // 0x27 + 1
    tbl[26] = mk(0, 0, 8'h7F, 8'h00);  // CGRAM 0x3F
    tbl[27] = mk(1, 0, 8'h99, 8'h00);
    tbl[28] = mk(0, 1, 8'h00, 8'h00);  // 6-bit wrap
    tbl[29] = mk(0, 0, 8'h7F, 8'h00);
    tbl[30] = mk(1, 1, 8'h00, 8'h99);
    tbl[31] = mk(0, 0, 8'h14, 8'h00);
    tbl[32] = mk(0, 1, 8'h00, 8'h01);
    tbl[33] = mk(0, 0, 8'h02, 8'h00);  // return home
    tbl[34] = mk(0, 1, 8'h00, 8'h00);

    for (int i = 0; i < 64; i++) m_cg_known[i] = 0;
    lcd.LCD_E = 1'b0; lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    wait_ready();
    for (int a = 0; a < 80; a++) scan_check(7'(a), 8'h20);

    for (int i = 0; i < 35; i++) begin
      wait_ready();
      xfer(tbl[i].rs, tbl[i].rw, tbl[i].dat, q);
      if (tbl[i].rw) check($sformatf("tbl[%0d]", i), q, tbl[i].exp);
    end
    check("disp_ctrl", disp_ctrl, 3'b100);
    check("func_n", func_n, 1);
    scan_check(7'h00, 8'h41);
    scan_check(7'h01, 8'h42);
    scan_check(7'h02, 8'h20);
    scan_check(7'h27, 8'h5A);
    scan_check(7'h40, 8'h5A);

    // Access while busy is dropped
    wait_ready(); xfer(0, 0, 8'h80, q);
    wait_ready();
    d0 = drop_cnt;
    xfer(1, 0, 8'h11, q);
    xfer(1, 0, 8'h77, q);
    check("drop pulses", drop_cnt - d0, 1);
    xfer(0, 1, 8'h00, q);
    check("BF during busy", q[7], 1);
    wait_ready();
    check("busy length", last_run, BUSY);
    xfer(0, 1, 8'h00, q);
    check("AC after drop", q, 8'h01);
    scan_check(7'h00, 8'h11);

    // Clear display
    wait_ready(); xfer(0, 0, 8'h04, q);
    wait_ready(); xfer(0, 0, 8'h01, q);
    wait_ready();
    check("clear busy length", last_run, CLEAR);
    xfer(0, 1, 8'h00, q);
    check("status after clear", q, 8'h00);
    for (int p = 0; p < 80; p++) scan_check(7'(legal_addr(p, 1)), 8'h20);
    xfer(1, 0, 8'h33, q);
    wait_ready();
    xfer(0, 1, 8'h00, q);
    check("I/D after clear", q, 8'h01);

    // Data read and bus release
    xfer(0, 0, 8'h85, q); wait_ready();
    xfer(1, 0, 8'hC3, q); wait_ready();
    xfer(0, 0, 8'h85, q); wait_ready();
    xfer(1, 1, 8'h00, q);
    check("data read 0x05", q, 8'hC3);
    wait_ready();
    xfer(0, 1, 8'h00, q);
    check("AC after read", q, 8'h06);
    @(negedge clk);
    lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b1; drv_en = 1'b0;
    repeat (2) @(negedge clk);
    check("hi-Z with E=0", LCD_data, 8'hFF);
    lcd.LCD_RW = 1'b0; lcd.LCD_E = 1'b1;
    repeat (2) @(negedge clk);
    check("hi-Z with RW=0", LCD_data, 8'hFF);
    lcd.LCD_RW = 1'b1;
    @(negedge clk);
    check("drive with E=1 RW=1", LCD_data, 8'h06);
    lcd.LCD_E = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during busy
    wait_ready(); xfer(1, 0, 8'h55, q);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_checks("mid-busy reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (85) @(negedge clk);
    wait_ready();
    xfer(0, 1, 8'h00, q);
    check("status after re-reset", q, 8'h00);
    scan_check(7'h00, 8'h20);
    scan_check(7'h06, 8'h20);
    scan_check(7'h4F, 8'h20);

    rand_phase(0);
    rand_phase(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
